// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, register-index type and zero-register constant for regfile_mp
package regfile_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_NUM_REGS      = 32;
    localparam int DEF_NUM_RD_PORTS  = 2;
    localparam int DEF_NUM_WR_PORTS  = 2;

    typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write flags per register: set at issue, cleared by writeback or flush
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int NUM_WR_PORTS  = DEF_NUM_WR_PORTS
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        set_en_i,
    input  logic [ADDRESS_WIDTH-1:0]                    set_dest_i,
    input  logic                                        flush_i,
    input  logic [NUM_WR_PORTS-1:0]                     wr_en_i,
    input  logic [NUM_WR_PORTS-1:0][ADDRESS_WIDTH-1:0]  wr_dest_i,
    output logic [NUM_REGS-1:0]                         busy_vec_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Priority, lowest to highest: hold, writeback clear, issue set, flush.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wr_en_i[p] && (32'(wr_dest_i[p]) == i)) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (set_en_i && (32'(set_dest_i) == i)) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with scoreboard; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int NUM_RD_PORTS  = DEF_NUM_RD_PORTS,
    parameter int NUM_WR_PORTS  = DEF_NUM_WR_PORTS
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_RD_PORTS-1:0][ADDRESS_WIDTH-1:0]  rg_rd_addr,
    output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]     rg_rd_data,
    output logic [NUM_RD_PORTS-1:0]                     rg_rd_busy,
    input  logic [NUM_WR_PORTS-1:0]                     rg_wrt_en,
    input  logic [NUM_WR_PORTS-1:0][ADDRESS_WIDTH-1:0]  rg_wrt_dest,
    input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0]     rg_wrt_data,
    input  logic                                        sb_set_en,
    input  logic [ADDRESS_WIDTH-1:0]                    sb_set_dest,
    input  logic                                        sb_flush,
    output logic [NUM_REGS-1:0]                         busy_vec
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Entry 0 is held at zero; out-of-range destinations never match any entry.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (rg_wrt_en[p] && (32'(rg_wrt_dest[p]) == i)) begin
                    regs_d[i] = rg_wrt_data[p];
                end
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    regfile_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_REGS      (NUM_REGS),
        .NUM_WR_PORTS  (NUM_WR_PORTS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (sb_set_en),
        .set_dest_i (sb_set_dest),
        .flush_i    (sb_flush),
        .wr_en_i    (rg_wrt_en),
        .wr_dest_i  (rg_wrt_dest),
        .busy_vec_o (busy_vec)
    );

    always_comb begin
        rg_rd_data = '0;
        rg_rd_busy = '0;
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (32'(rg_rd_addr[k]) == i) begin
                    rg_rd_data[k] = regs_q[i];
                    rg_rd_busy[k] = busy_vec[i];
                end
            end
`ifdef REGFILE_BYPASS_EN
            // Later ports override earlier ones, matching the write-port priority.
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (rg_wrt_en[p] && (rg_rd_addr[k] == rg_wrt_dest[p]) &&
                    (rg_rd_addr[k] != ADDRESS_WIDTH'(ZERO_REG)) &&
                    (32'(rg_rd_addr[k]) < NUM_REGS)) begin
                    rg_rd_data[k] = rg_wrt_data[p];
                    rg_rd_busy[k] = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard-driven bench for regfile_mp (default build and 16-reg/4-read-port build)
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;
    logic [1:0]       we;
    logic [1:0][4:0]  wd;
    logic [1:0][31:0] wdat;
    logic             set_en;
    logic [4:0]       set_dest;
    logic             flush;
    logic [31:0]      busy_vec;

    logic [3:0][4:0]  rd_addr2;
    logic [3:0][31:0] rd_data2;
    logic [3:0]       rd_busy2;
    logic [1:0]       we2;
    logic [1:0][4:0]  wd2;
    logic [1:0][31:0] wdat2;
    logic             set_en2;
    logic [4:0]       set_dest2;
    logic             flush2;
    logic [15:0]      busy_vec2;

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .rg_rd_addr(rd_addr), .rg_rd_data(rd_data), .rg_rd_busy(rd_busy),
        .rg_wrt_en(we), .rg_wrt_dest(wd), .rg_wrt_data(wdat),
        .sb_set_en(set_en), .sb_set_dest(set_dest), .sb_flush(flush),
        .busy_vec(busy_vec)
    );

    regfile_mp #(.NUM_REGS(16), .NUM_RD_PORTS(4)) dut16 (
        .clk(clk), .rst(rst),
        .rg_rd_addr(rd_addr2), .rg_rd_data(rd_data2), .rg_rd_busy(rd_busy2),
        .rg_wrt_en(we2), .rg_wrt_dest(wd2), .rg_wrt_data(wdat2),
        .sb_set_en(set_en2), .sb_set_dest(set_dest2), .sb_flush(flush2),
        .busy_vec(busy_vec2)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] r;
        r = (a == 5'd0) ? 32'd0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < 2; p++)
            if (we[p] && wd[p] == a && a != 5'd0) r = wdat[p];
`endif
        return r;
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        logic b;
        b = (a == 5'd0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < 2; p++)
            if (we[p] && wd[p] == a && a != 5'd0) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_step();
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                if (we[p] && wd[p] != 5'd0) begin
                    m_regs[wd[p]] = wdat[p];
                    m_busy[wd[p]] = 1'b0;
                end
            end
            if (set_en && set_dest != 5'd0) m_busy[set_dest] = 1'b1;
            if (flush) m_busy = '0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        we = '0; set_en = 1'b0; flush = 1'b0;
        we2 = '0; set_en2 = 1'b0; flush2 = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr[0] = a0;
        rd_addr[1] = a1;
        exp_q.push_back(m_read(a0));
        exp_q.push_back(32'(m_rbusy(a0)));
        exp_q.push_back(m_read(a1));
        exp_q.push_back(32'(m_rbusy(a1)));
    endtask

    task automatic sample(input string tag);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (exp_q.size() < 2) begin
                chk({tag, "_queue"}, 32'(exp_q.size()), 32'd2);
            end else begin
                chk($sformatf("%s_data%0d", tag, k), rd_data[k], exp_q.pop_front());
                chk($sformatf("%s_busy%0d", tag, k), 32'(rd_busy[k]), exp_q.pop_front());
            end
        end
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        we[p] = 1'b1; wd[p] = a; wdat[p] = d;
    endtask

    task automatic sbset(input logic [4:0] a);
        set_en = 1'b1; set_dest = a;
    endtask

    initial begin
        rst = 1'b0;
        rd_addr = '0; we = '0; wd = '0; wdat = '0; set_en = 0; set_dest = '0; flush = 0;
        rd_addr2 = '0; we2 = '0; wd2 = '0; wdat2 = '0; set_en2 = 0; set_dest2 = '0; flush2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy_vec", busy_vec, 32'd0);
        rd(5'd5, 5'd1); sample("reset_read");

        wr(0, 5'd5, 32'h0000_0001); sbset(5'd5); tick();
        rd(5'd5, 5'd5); sample("write_in_reset");
        chk("busy_in_reset", busy_vec, 32'd0);

        rst = 1'b1;
        wr(0, 5'd1, 32'hA5A5_A5A5); tick();
        rd(5'd1, 5'd0); sample("first_write");

        wr(0, 5'd5, 32'hDEAD_BEEF); sbset(5'd6); tick();
        rd(5'd5, 5'd6); sample("r5_written");
        chk("r5_busy_vec", busy_vec, 32'h0000_0040);
        #2 rst = 1'b0;
        model_reset();
        rd(5'd5, 5'd6); sample("async_reset");
        chk("async_reset_busy_vec", busy_vec, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); tick();
        rd(5'd7, 5'd7); sample("dual_conflict");
        chk("conflict_r7", rd_data[0], 32'h22);

        wr(0, 5'd0, 32'hFFFF_FFFF); sbset(5'd0);
        rd(5'd0, 5'd0); sample("r0_during_write");
        tick();
        rd(5'd0, 5'd0); sample("r0_after_write");
        chk("r0_busy", 32'(busy_vec[0]), 32'd0);

        sbset(5'd3); tick();
        rd(5'd3, 5'd4); sample("sb_set_r3");
        wr(0, 5'd3, 32'h33); sbset(5'd3); tick();
        rd(5'd3, 5'd3); sample("sb_set_wins");
        chk("sb_set_wins_vec", 32'(busy_vec[3]), 32'd1);
        wr(1, 5'd3, 32'h44); tick();
        rd(5'd3, 5'd4); sample("sb_write_clears");
        sbset(5'd4); flush = 1'b1; tick();
        rd(5'd4, 5'd3); sample("sb_flush");
        chk("flush_busy_vec", busy_vec, 32'd0);

        wr(0, 5'd9, 32'h55); tick();
        sbset(5'd9); tick();
        wr(1, 5'd9, 32'h1234); rd(5'd9, 5'd9); sample("bypass");
`ifdef REGFILE_BYPASS_EN
        chk("bypass_data", rd_data[0], 32'h1234);
        chk("bypass_busy", 32'(rd_busy[0]), 32'd0);
`else
        chk("nobypass_data", rd_data[0], 32'h55);
        chk("nobypass_busy", 32'(rd_busy[0]), 32'd1);
`endif
        tick();
        rd(5'd9, 5'd0); sample("after_bypass");

        for (int it = 0; it < 80; it++) begin
            for (int p = 0; p < 2; p++) begin
                we[p] = 1'($urandom_range(0, 1));
                wd[p] = 5'($urandom_range(0, 31));
                wdat[p] = $urandom;
            end
            set_en = ($urandom_range(0, 2) == 0);
            set_dest = 5'($urandom_range(0, 31));
            flush = ($urandom_range(0, 9) == 0);
            rd($urandom_range(0, 1) ? wd[1] : 5'($urandom_range(0, 31)),
               $urandom_range(0, 1) ? wd[0] : set_dest);
            sample($sformatf("rand%0d", it));
            chk($sformatf("rand%0d_vec", it), busy_vec, m_busy);
            tick();
        end

        we2[1] = 1'b1; wd2[1] = 5'd15; wdat2[1] = 32'hCAFE_F00D;
        we2[0] = 1'b1; wd2[0] = 5'd16; wdat2[0] = 32'h77;
        set_en2 = 1'b1; set_dest2 = 5'd16;
        tick();
        rd_addr2[0] = 5'd15; rd_addr2[1] = 5'd16; rd_addr2[2] = 5'd0; rd_addr2[3] = 5'd15;
        #1;
        chk("p16_r15_port0", rd_data2[0], 32'hCAFE_F00D);
        chk("p16_r16_port1", rd_data2[1], 32'd0);
        chk("p16_r15_port3", rd_data2[3], 32'hCAFE_F00D);
        chk("p16_busy_r16", 32'(rd_busy2[1]), 32'd0);
        chk("p16_busy_vec", 32'(busy_vec2), 32'd0);
        set_en2 = 1'b1; set_dest2 = 5'd15;
        tick();
        #1;
        chk("p16_busy_r15", 32'(rd_busy2[3]), 32'd1);
        chk("p16_busy_vec_r15", 32'(busy_vec2), 32'h0000_8000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bits per register.
REQ-002 Parameter ADDRESS_WIDTH, default 5, register address width.
REQ-003 Parameter NUM_REGS, default 32, register count; SHALL be at most 2**ADDRESS_WIDTH.
REQ-004 Parameter NUM_RD_PORTS, default 2, independent read ports (1..4).
REQ-005 Parameter NUM_WR_PORTS, default 2, independent write ports (1..2).
REQ-006 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 Port rst, input, 1, asynchronous active-low reset.
REQ-008 Port rg_rd_addr, input, NUM_RD_PORTS x ADDRESS_WIDTH, read addresses.
REQ-009 Port rg_rd_data, output, NUM_RD_PORTS x DATA_WIDTH, read data.
REQ-010 Port rg_rd_busy, output, NUM_RD_PORTS, pending-write flag of each read address.
REQ-011 Port rg_wrt_en, input, NUM_WR_PORTS, per-port write enable.
REQ-012 Port rg_wrt_dest, input, NUM_WR_PORTS x ADDRESS_WIDTH, write addresses.
REQ-013 Port rg_wrt_data, input, NUM_WR_PORTS x DATA_WIDTH, write data.
REQ-014 Port sb_set_en / sb_set_dest, input, 1 / ADDRESS_WIDTH, mark destination pending at issue.
REQ-015 Port sb_flush, input, 1, clear all pending flags.
REQ-016 Port busy_vec, output, NUM_REGS, scoreboard state.

Function
REQ-017 Read ports SHALL be combinational from register array (zero-cycle latency).
REQ-018 Register 0 SHALL read 0, ignore writes, never be pending.
REQ-019 Enabled write SHALL update register rg_wrt_dest at next rising edge.
REQ-020 Two ports writing same address same cycle: higher-index port wins.
REQ-021 Address >= NUM_REGS: write ignored, read returns 0, busy reads 0.
REQ-022 sb_set_en SHALL set busy_vec[sb_set_dest] at next edge.
REQ-023 Enabled write to a register SHALL clear its busy bit at next edge.
REQ-024 Set and write-clear to same register same cycle: set wins (bit stays 1).
REQ-025 sb_flush SHALL clear all busy bits at next edge, overriding sb_set_en; register contents unaffected.
REQ-026 rg_rd_busy[k] SHALL equal busy_vec[rg_rd_addr[k]] as currently registered.

Reset
REQ-027 rst low SHALL immediately clear all registers and busy_vec to 0, independent of clk.
REQ-028 Writes, sets and flush during reset SHALL be ignored; in-flight pending state SHALL be lost.
REQ-029 First write SHALL take effect on first rising edge after rst deasserts.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: a read whose address matches an enabled write the same cycle SHALL return rg_wrt_data (highest matching port) and rg_rd_busy 0; register 0 excluded.
REQ-031 REGFILE_BYPASS_EN undefined: reads return stored value only; new data visible cycle after write.

Structure
REQ-032 Package regfile_pkg SHALL hold default widths, reg-index type and zero-register constant.
REQ-033 Scoreboard SHALL be sub-module regfile_scoreboard (busy_vec, set/clear/flush priority).
REQ-034 Read-mux/bypass SHALL be combinational in top module; no further sub-modules.

Verification
REQ-035 Reset mid-run: write 0xDEADBEEF to r5, pull rst low between edges -> rg_rd_data(r5)=0 immediately, busy_vec=0.
REQ-036 Dual write conflict: port0 r7=0x11, port1 r7=0x22 same cycle -> r7 reads 0x22 next cycle.
REQ-037 Register 0: write 0xFFFFFFFF to r0, sb_set r0 -> reads 0, busy_vec[0]=0.
REQ-038 Scoreboard: set r3, next cycle write r3 with set r3 same cycle -> busy stays 1; later write alone -> 0; set r4+flush -> 0.
REQ-039 Bypass: write r9=0x1234 while reading r9 -> 0x1234 same cycle with REGFILE_BYPASS_EN, old value without.
REQ-040 Parameter sweep: NUM_REGS=16, NUM_RD_PORTS=4, read/write r15 and r16 -> r15 round-trips, r16 read 0.
